// File: rtl/vram_ctrl_pkg.sv
// rtl/vram_ctrl_pkg.sv - shared register map, bit positions and state encoding for the VRAM flip controller
//
// Purpose: control-word offsets relative to CTRL_BASE, CTRL/STATUS bit indices
//          and the sequencer state enum used by vram_flip_controller.
// Ports:   none (package).
package vram_ctrl_pkg;

  localparam logic [31:0] REG_CTRL_OFF        = 32'h0;
  localparam logic [31:0] REG_STATUS_OFF      = 32'h4;
  localparam logic [31:0] REG_CLEAR_COLOR_OFF = 32'h8;

  localparam int CTRL_TARGET_BIT = 0;
  localparam int CTRL_SYNC_BIT   = 1;
  localparam int CTRL_CLEAR_BIT  = 2;

  localparam int STATUS_ACTIVE_BIT  = 0;
  localparam int STATUS_PENDING_BIT = 1;
  localparam int STATUS_BUSY_BIT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PASS     = 2'd1,
    ST_WAIT_VBL = 2'd2,
    ST_CLEAR    = 2'd3
  } state_t;

endpackage

// File: rtl/vram_clear_engine.sv
// rtl/vram_clear_engine.sv - word counter that walks a VRAM page for the post-swap clear
//
// Purpose: holds the index of the clear word currently in flight. i_start parks
//          the counter on word 0; each i_advance (VRAM accepted the current word)
//          steps to the next word. o_done flags the accept of the final word.
// Ports:
//   i_clock         in   1   system clock
//   i_reset_n       in   1   asynchronous active-low reset
//   i_start         in   1   restart at word 0
//   i_advance       in   1   current word completed
//   o_next_address  out  32  byte address of the word after the current one
//   o_done          out  1   current word was the last one and just completed
module vram_clear_engine #(
  parameter int unsigned PAGE_WORDS = 65536
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_advance,
  output logic [31:0] o_next_address,
  output logic        o_done
);

  localparam int unsigned CW = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(PAGE_WORDS - 1);

  logic [CW-1:0] count_q, count_d;
  logic          last_word;

  assign last_word = (count_q == LAST_WORD);

  always_comb begin
    count_d = count_q;
    if (i_start) begin
      count_d = '0;
    end else if (i_advance && !last_word) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_next_address = (32'(count_q) + 32'd1) << 2;
  assign o_done         = i_advance & last_word;

endmodule

// File: rtl/vram_flip_controller.sv
// rtl/vram_flip_controller.sv - double-buffered VRAM sequencer: page flip, vblank sync, CPU pixel forwarding
//
// Purpose: owns the active-page select, defers CPU flip requests to the next
//          vblank rising edge, forwards CPU pixel accesses to the back page.
//          Optional post-swap page clear is built when VRAM_FLIP_CLEAR_EN is defined.
// Ports:
//   i_clock, i_reset_n                      clock, asynchronous active-low reset
//   i_request, i_rw, i_address, i_wdata     CPU request (held until o_ready)
//   o_rdata, o_ready                        CPU read data, one-cycle completion
//   i_vblank                                vertical blank level
//   o_vram_request, o_vram_rw,
//   o_vram_address, o_vram_wdata            back-page access (request is a pulse)
//   i_vram_ready                            VRAM completion pulse
//   o_active                                presented page (0 = page1)
//   o_irq                                   one-cycle pulse per completed swap
module vram_flip_controller
  import vram_ctrl_pkg::*;
#(
  parameter logic [31:0] CTRL_BASE  = 32'h0fff_fff0,
  parameter int unsigned PAGE_WORDS = 65536
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        i_vblank,
  output logic        o_vram_request,
  output logic        o_vram_rw,
  output logic [31:0] o_vram_address,
  output logic [23:0] o_vram_wdata,
  input  logic        i_vram_ready,
  output logic        o_active,
  output logic        o_irq
);

  localparam logic [31:0] CTRL_ADDR   = CTRL_BASE + REG_CTRL_OFF;
  localparam logic [31:0] STATUS_ADDR = CTRL_BASE + REG_STATUS_OFF;
  localparam logic [31:0] COLOR_ADDR  = CTRL_BASE + REG_CLEAR_COLOR_OFF;

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic        irq_q, irq_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pending_q, pending_d;
  logic        target_q, target_d;
  logic        sync_q, sync_d;
  logic        clear_q, clear_d;
  logic        vblank_prev_q, vblank_prev_d;
  logic        vram_req_q, vram_req_d;
  logic        vram_rw_q, vram_rw_d;
  logic [31:0] vram_addr_q, vram_addr_d;
  logic [23:0] vram_wdata_q, vram_wdata_d;

  logic        accept;
  logic        hit_ctrl, hit_status, hit_color;
  logic        vblank_rise;
  logic [31:0] status_word;
  logic        unused_wdata;

  // The CPU keeps i_request high through the o_ready cycle, so that cycle
  // must not be mistaken for a fresh request.
  assign accept      = (state_q == ST_IDLE) && i_request && !ready_q;
  assign hit_ctrl    = (i_address[31:2] == CTRL_ADDR[31:2]);
  assign hit_status  = (i_address[31:2] == STATUS_ADDR[31:2]);
  assign hit_color   = (i_address[31:2] == COLOR_ADDR[31:2]);
  assign vblank_rise = i_vblank && !vblank_prev_q;
  assign unused_wdata = ^i_wdata[31:24];

`ifdef VRAM_FLIP_CLEAR_EN
  logic [23:0] clear_color_q, clear_color_d;
  logic        clear_start;
  logic        clear_done;
  logic [31:0] clear_next_addr;

  vram_clear_engine #(
    .PAGE_WORDS (PAGE_WORDS)
  ) u_clear (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_start        (clear_start),
    .i_advance      ((state_q == ST_CLEAR) && i_vram_ready),
    .o_next_address (clear_next_addr),
    .o_done         (clear_done)
  );
`endif

  always_comb begin
    status_word = '0;
    status_word[STATUS_ACTIVE_BIT]  = active_q;
    status_word[STATUS_PENDING_BIT] = pending_q;
`ifdef VRAM_FLIP_CLEAR_EN
    status_word[STATUS_BUSY_BIT]    = (state_q == ST_CLEAR);
`else
    status_word[STATUS_BUSY_BIT]    = 1'b0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    irq_d         = 1'b0;
    ready_d       = 1'b0;
    rdata_d       = '0;
    pending_d     = pending_q;
    target_d      = target_q;
    sync_d        = sync_q;
    clear_d       = clear_q;
    vblank_prev_d = i_vblank;
    vram_req_d    = 1'b0;
    vram_rw_d     = vram_rw_q;
    vram_addr_d   = vram_addr_q;
    vram_wdata_d  = vram_wdata_q;
`ifdef VRAM_FLIP_CLEAR_EN
    clear_color_d = clear_color_q;
    clear_start   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit_ctrl) begin
            ready_d = 1'b1;
            if (i_rw) begin
              target_d = i_wdata[CTRL_TARGET_BIT];
              sync_d   = i_wdata[CTRL_SYNC_BIT];
`ifdef VRAM_FLIP_CLEAR_EN
              clear_d  = i_wdata[CTRL_CLEAR_BIT];
`else
              clear_d  = 1'b0;
`endif
              // Requesting the page already shown is a no-op.
              if (i_wdata[CTRL_TARGET_BIT] != active_q) begin
                pending_d = 1'b1;
                state_d   = ST_WAIT_VBL;
              end
            end else begin
              rdata_d[CTRL_TARGET_BIT] = target_q;
              rdata_d[CTRL_SYNC_BIT]   = sync_q;
              rdata_d[CTRL_CLEAR_BIT]  = clear_q;
            end
          end else if (hit_status) begin
            ready_d = 1'b1;
            if (!i_rw) begin
              rdata_d = status_word;
            end
          end else if (hit_color) begin
            ready_d = 1'b1;
`ifdef VRAM_FLIP_CLEAR_EN
            if (i_rw) begin
              clear_color_d = i_wdata[23:0];
            end else begin
              rdata_d = {8'h00, clear_color_q};
            end
`endif
          end else begin
            state_d      = ST_PASS;
            vram_req_d   = 1'b1;
            vram_rw_d    = i_rw;
            vram_addr_d  = i_address;
            vram_wdata_d = i_wdata[23:0];
          end
        end
      end

      ST_PASS: begin
        if (i_vram_ready) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_VBL: begin
        // Unsynchronised flips swap on the first WAIT_VBL cycle; synchronised
        // ones need a genuine low-to-high transition seen from inside this state.
        if (!sync_q || vblank_rise) begin
          active_d  = target_q;
          irq_d     = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_IDLE;
`ifdef VRAM_FLIP_CLEAR_EN
          if (clear_q) begin
            state_d      = ST_CLEAR;
            clear_start  = 1'b1;
            vram_req_d   = 1'b1;
            vram_rw_d    = 1'b1;
            vram_addr_d  = '0;
            vram_wdata_d = clear_color_q;
          end
`endif
        end
      end

      ST_CLEAR: begin
`ifdef VRAM_FLIP_CLEAR_EN
        if (i_vram_ready) begin
          if (clear_done) begin
            state_d = ST_IDLE;
          end else begin
            vram_req_d  = 1'b1;
            vram_addr_d = clear_next_addr;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      active_q      <= 1'b0;
      irq_q         <= 1'b0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      pending_q     <= 1'b0;
      target_q      <= 1'b0;
      sync_q        <= 1'b0;
      clear_q       <= 1'b0;
      vblank_prev_q <= 1'b0;
      vram_req_q    <= 1'b0;
      vram_rw_q     <= 1'b0;
      vram_addr_q   <= '0;
      vram_wdata_q  <= '0;
`ifdef VRAM_FLIP_CLEAR_EN
      clear_color_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      irq_q         <= irq_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      pending_q     <= pending_d;
      target_q      <= target_d;
      sync_q        <= sync_d;
      clear_q       <= clear_d;
      vblank_prev_q <= vblank_prev_d;
      vram_req_q    <= vram_req_d;
      vram_rw_q     <= vram_rw_d;
      vram_addr_q   <= vram_addr_d;
      vram_wdata_q  <= vram_wdata_d;
`ifdef VRAM_FLIP_CLEAR_EN
      clear_color_q <= clear_color_d;
`endif
    end
  end

  assign o_rdata        = rdata_q;
  assign o_ready        = ready_q;
  assign o_vram_request = vram_req_q;
  assign o_vram_rw      = vram_rw_q;
  assign o_vram_address = vram_addr_q;
  assign o_vram_wdata   = vram_wdata_q;
  assign o_active       = active_q;
  assign o_irq          = irq_q;

endmodule
